// File: rtl/exc_unit.sv
// exc_unit: MEM-stage precise exception and CP0 unit (Status, Cause, EPC, BadVAddr).
// Optional Count/Compare timer interrupt on IP[15] is built when TIMER_INT_EN is defined.

module exc_unit #(
   parameter int          HW_INT  = 5,
   parameter logic [31:0] EXC_VEC = 32'hBFC0_0380
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_M,
   input  logic [31:0]       PC_M,
   input  logic              BD_M,
   input  logic [1:0]        S_SEL_M,
   input  logic [31:0]       SL_Addr,
   input  logic              DM_REN_M,
   input  logic              DM_WEN_M,
   input  logic              RI,
   input  logic              brk,
   input  logic              syscall,
   input  logic              eret,
   input  logic              Overable,
   input  logic              Over,
   input  logic [HW_INT-1:0] HWInt,
   input  logic              mtc0_we,
   input  logic [4:0]        cp0_addr,
   input  logic [31:0]       cp0_wdata,
   output logic [31:0]       cp0_rdata,
   output logic              Exc,
   output logic [4:0]        ExcCode,
   output logic              flush,
   output logic [31:0]       redirect_pc
);

   typedef enum logic [4:0] {
      EXC_INT  = 5'h00,
      EXC_ADEL = 5'h04,
      EXC_ADES = 5'h05,
      EXC_SYS  = 5'h08,
      EXC_BP   = 5'h09,
      EXC_RI   = 5'h0a,
      EXC_OV   = 5'h0c
   } exc_code_e;

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   logic [5:0]        r_im;
   logic              r_exl;
   logic              r_ie;
   logic              r_bd;
   logic [4:0]        r_exccode;
   logic [31:0]       r_epc;
   logic [31:0]       r_badvaddr;
   logic [HW_INT-1:0] r_ip_hw;

   logic [4:0]        w_hw_pad;
   logic [5:0]        w_ip;
   logic              w_ti;
   logic [31:0]       w_count;
   logic [31:0]       w_compare;
   logic              w_misalign;
   logic              w_int_req;
   logic              w_exc;
   logic              w_badv_pc;
   logic              w_badv_sl;
   logic              w_eret_taken;
   logic              w_wr;
   exc_code_e         w_code;

   always_comb begin
      w_hw_pad                = '0;
      w_hw_pad[HW_INT-1:0]    = r_ip_hw;
   end

   assign w_ip = {w_ti, w_hw_pad};

`ifdef TIMER_INT_EN
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_ti;
   logic [31:0] w_count_nxt;
   logic [31:0] w_compare_nxt;
   logic        w_wr_compare;

   assign w_wr_compare  = w_wr && (cp0_addr == REG_COMPARE);
   assign w_count_nxt   = (w_wr && (cp0_addr == REG_COUNT)) ? cp0_wdata : r_count + 32'd1;
   assign w_compare_nxt = w_wr_compare ? cp0_wdata : r_compare;

   // TI is set from the post-update Count/Compare pair, so a Compare write only
   // clears it when the new values do not already match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count   <= '0;
         r_compare <= '0;
         r_ti      <= 1'b0;
      end else begin
         r_count   <= w_count_nxt;
         r_compare <= w_compare_nxt;
         if (w_count_nxt == w_compare_nxt)
            r_ti <= 1'b1;
         else if (w_wr_compare)
            r_ti <= 1'b0;
      end
   end

   assign w_count   = r_count;
   assign w_compare = r_compare;
   assign w_ti      = r_ti;
`else
   assign w_count   = '0;
   assign w_compare = '0;
   assign w_ti      = 1'b0;
`endif

   assign w_misalign = ((S_SEL_M == 2'b00) && (SL_Addr[1:0] != 2'b00)) ||
                       ((S_SEL_M == 2'b01) && SL_Addr[0]);
   assign w_int_req  = valid_M && r_ie && !r_exl && ((w_ip & r_im) != 6'd0);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_exc     = 1'b0;
      w_code    = EXC_INT;
      w_badv_pc = 1'b0;
      w_badv_sl = 1'b0;
      if (valid_M && !reset) begin
         if (w_int_req) begin
            w_exc  = 1'b1;
            w_code = EXC_INT;
         end else if (PC_M[1:0] != 2'b00) begin
            w_exc     = 1'b1;
            w_code    = EXC_ADEL;
            w_badv_pc = 1'b1;
         end else if (RI) begin
            w_exc  = 1'b1;
            w_code = EXC_RI;
         end else if (Overable && Over) begin
            w_exc  = 1'b1;
            w_code = EXC_OV;
         end else if (syscall) begin
            w_exc  = 1'b1;
            w_code = EXC_SYS;
         end else if (brk) begin
            w_exc  = 1'b1;
            w_code = EXC_BP;
         end else if (DM_REN_M && w_misalign) begin
            w_exc     = 1'b1;
            w_code    = EXC_ADEL;
            w_badv_sl = 1'b1;
         end else if (DM_WEN_M && w_misalign) begin
            w_exc     = 1'b1;
            w_code    = EXC_ADES;
            w_badv_sl = 1'b1;
         end
      end
   end

   assign w_eret_taken = valid_M && eret && !w_exc && !reset;
   assign w_wr         = mtc0_we && !w_exc;

   assign Exc         = w_exc;
   assign ExcCode     = w_code;
   assign flush       = w_exc || w_eret_taken;
   assign redirect_pc = w_exc ? EXC_VEC : (w_eret_taken ? r_epc : 32'd0);

   // NOTE: sequential state uses non-blocking assignments so every register sees
   // the pre-edge values of its peers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_im       <= '0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_exccode  <= '0;
         r_epc      <= '0;
         r_badvaddr <= '0;
         r_ip_hw    <= '0;
      end else begin
         r_ip_hw <= HWInt;
         if (w_exc) begin
            r_exl     <= 1'b1;
            r_exccode <= w_code;
            if (!r_exl) begin
               r_bd  <= BD_M;
               r_epc <= BD_M ? PC_M - 32'd4 : PC_M;
            end
            if (w_badv_pc)
               r_badvaddr <= PC_M;
            else if (w_badv_sl)
               r_badvaddr <= SL_Addr;
         end else begin
            if (w_wr && (cp0_addr == REG_STATUS)) begin
               r_im  <= cp0_wdata[15:10];
               r_exl <= cp0_wdata[1];
               r_ie  <= cp0_wdata[0];
            end
            if (w_wr && (cp0_addr == REG_EPC))
               r_epc <= cp0_wdata;
            if (w_eret_taken)
               r_exl <= 1'b0;
         end
      end
   end

   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         REG_BADVADDR: cp0_rdata = r_badvaddr;
         REG_COUNT:    cp0_rdata = w_count;
         REG_COMPARE:  cp0_rdata = w_compare;
         REG_STATUS:   cp0_rdata = {16'h0, r_im, 8'h0, r_exl, r_ie};
         REG_CAUSE:    cp0_rdata = {r_bd, w_ti, 14'h0, w_ip, 3'b000, r_exccode, 2'b00};
         REG_EPC:      cp0_rdata = r_epc;
         default:      cp0_rdata = '0;
      endcase
   end

endmodule
